// File: rtl/alu_16bit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the two-requester ALU arbiter:
//                opcode encodings, arbiter FSM state type and the bit
//                positions of the compare vector.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // ALU opcode encodings (3-bit field, all eight values defined)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

    // Bit positions inside the 3-bit compare vector
    localparam int CMP_LT = 2;
    localparam int CMP_GT = 1;
    localparam int CMP_EQ = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_16bit_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_16bit_arbiter_if
//  Description : Bundle of the two request channels and the tagged response
//                channel of the ALU arbiter.
//                slave  modport : arbiter side (accepts requests, drives
//                                 responses)
//                master modport : requester / consumer side
//  Parameters  : DATA_W - operand and result width
//  Signals     : reqN_valid/ready, reqN_opcode[2:0], reqN_a, reqN_b, reqN_cin
//                rsp_valid/ready, rsp_id, rsp_result, rsp_mul_high,
//                rsp_mul_low, rsp_compare[2:0], rsp_parity, rsp_overflow,
//                rsp_c_out
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_16bit_arbiter_if #(
    parameter int DATA_W = 16
);
    // Requester 0
    logic              req0_valid;
    logic              req0_ready;
    logic [2:0]        req0_opcode;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_cin;
    // Requester 1
    logic              req1_valid;
    logic              req1_ready;
    logic [2:0]        req1_opcode;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_cin;
    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic [DATA_W-1:0] rsp_mul_high;
    logic [DATA_W-1:0] rsp_mul_low;
    logic [2:0]        rsp_compare;
    logic              rsp_parity;
    logic              rsp_overflow;
    logic              rsp_c_out;

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_a, req1_b, req1_cin,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_mul_high, rsp_mul_low,
        output rsp_compare, rsp_parity, rsp_overflow, rsp_c_out,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_mul_high, rsp_mul_low,
        input  rsp_compare, rsp_parity, rsp_overflow, rsp_c_out,
        output rsp_ready
    );

endinterface : alu_16bit_arbiter_if
`default_nettype wire

// File: rtl/alu_16bit_arbiter_alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_16bit
//  Description : Purely combinational ALU shared by the arbiter.
//                result   : ADD a+b+cin, SUB a-b-cin, AND, OR,
//                           EQ/GT/LT -> 0/1 in bit 0 (unsigned compare),
//                           MUL -> 0 (product is on mul_high/mul_low)
//                compare  : {LT,GT,EQ} of a vs b, unsigned, every opcode
//                mul_*    : full unsigned product a*b, every opcode
//                c_out    : carry (ADD) / borrow (SUB), else 0
//                overflow : signed overflow (ADD/SUB), product wider than
//                           WIDTH (MUL), else 0
//                parity   : XOR reduction of result
//  Ports       : opcode[2:0], a, b, cin (in); result, mul_high, mul_low,
//                compare[2:0], parity, overflow, c_out (out)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_16bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mul_high,
    output logic [WIDTH-1:0] mul_low,
    output logic [2:0]       compare,
    output logic             parity,
    output logic             overflow,
    output logic             c_out
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] product;
    logic               add_ovf;
    logic               sub_ovf;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        // Top bit of the extended difference is the borrow out
        diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        // Same-sign operands producing a different-sign sum; for a-b the
        // subtrahend's sign is effectively inverted
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

        compare         = 3'b000;
        compare[CMP_LT] = (a <  b);
        compare[CMP_GT] = (a >  b);
        compare[CMP_EQ] = (a == b);

        result   = '0;
        overflow = 1'b0;
        c_out    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result   = sum[WIDTH-1:0];
                c_out    = sum[WIDTH];
                overflow = add_ovf;
            end
            OP_SUB: begin
                result   = diff[WIDTH-1:0];
                c_out    = diff[WIDTH];
                overflow = sub_ovf;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_EQ:  result = {{(WIDTH-1){1'b0}}, compare[CMP_EQ]};
            OP_GT:  result = {{(WIDTH-1){1'b0}}, compare[CMP_GT]};
            OP_LT:  result = {{(WIDTH-1){1'b0}}, compare[CMP_LT]};
            OP_MUL: overflow = |product[2*WIDTH-1:WIDTH];
            default: result = '0;
        endcase

        mul_high = product[2*WIDTH-1:WIDTH];
        mul_low  = product[WIDTH-1:0];
        parity   = ^result;
    end

endmodule : alu_16bit
`default_nettype wire

// File: rtl/alu_16bit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_16bit_arbiter
//  Description : Shares one alu_16bit between two requesters. A round-robin
//                winner is accepted in IDLE, its operands are registered,
//                the ALU runs for one cycle (EXEC) and its outputs are
//                captured and presented on a tagged response channel (RESP)
//                until the consumer takes them.
//  Parameters  : DATA_W - operand/result width (must be 16)
//                CNT_W  - statistics counter width
//  Ports       : clk, rst_n (async, active low)
//                bus          - alu_16bit_arbiter_if.slave
//                stat_grant0/1 - saturating accept counters
//                                (only with ALU_ARB_STATS_EN defined)
//  Config      : `define ALU_ARB_STATS_EN to build the accept counters
//  Revision    : 1.0  initial release
// ============================================================================
module alu_16bit_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_16bit_arbiter_if.slave   bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_grant0,
    output logic [CNT_W-1:0]     stat_grant1
`endif
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EXEC = EXEC;
    localparam logic [1:0] S_RESP = RESP;

    if (DATA_W != 16) begin : g_data_w_check
        $error("alu_16bit_arbiter: DATA_W must be 16");
    end
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("alu_16bit_arbiter: CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // State and operand registers
    // ------------------------------------------------------------------
    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [2:0]        op_opcode_q,  op_opcode_d;
    logic [DATA_W-1:0] op_a_q,       op_a_d;
    logic [DATA_W-1:0] op_b_q,       op_b_d;
    logic              op_cin_q,     op_cin_d;
    logic              op_id_q,      op_id_d;

    // Captured response registers
    logic              rsp_id_q,       rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q,   rsp_result_d;
    logic [DATA_W-1:0] rsp_mul_high_q, rsp_mul_high_d;
    logic [DATA_W-1:0] rsp_mul_low_q,  rsp_mul_low_d;
    logic [2:0]        rsp_compare_q,  rsp_compare_d;
    logic              rsp_parity_q,   rsp_parity_d;
    logic              rsp_overflow_q, rsp_overflow_d;
    logic              rsp_c_out_q,    rsp_c_out_d;

    // ALU outputs
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_mul_high;
    logic [DATA_W-1:0] alu_mul_low;
    logic [2:0]        alu_compare;
    logic              alu_parity;
    logic              alu_overflow;
    logic              alu_c_out;

    // Arbitration
    logic              is_idle;
    logic              grant0;
    logic              grant1;

    // ------------------------------------------------------------------
    // Round-robin winner: a lone requester always wins; on a tie the
    // requester that was not granted last time wins. Ready is purely
    // combinational from the valids so nothing is reserved across cycles.
    // ------------------------------------------------------------------
    always_comb begin
        is_idle = (state_q == S_IDLE);
        grant0  = is_idle && bus.req0_valid && !(bus.req1_valid && !last_grant_q);
        grant1  = is_idle && bus.req1_valid && !(bus.req0_valid &&  last_grant_q);
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // ------------------------------------------------------------------
    // Shared ALU, fed only from the operand registers
    // ------------------------------------------------------------------
    alu_16bit #(
        .WIDTH (DATA_W)
    ) u_alu (
        .opcode   (op_opcode_q),
        .a        (op_a_q),
        .b        (op_b_q),
        .cin      (op_cin_q),
        .result   (alu_result),
        .mul_high (alu_mul_high),
        .mul_low  (alu_mul_low),
        .compare  (alu_compare),
        .parity   (alu_parity),
        .overflow (alu_overflow),
        .c_out    (alu_c_out)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        op_opcode_d    = op_opcode_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_cin_d       = op_cin_q;
        op_id_d        = op_id_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_mul_high_d = rsp_mul_high_q;
        rsp_mul_low_d  = rsp_mul_low_q;
        rsp_compare_d  = rsp_compare_q;
        rsp_parity_d   = rsp_parity_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_c_out_d    = rsp_c_out_q;

        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    // grant1 doubles as the winner index
                    op_opcode_d  = grant1 ? bus.req1_opcode : bus.req0_opcode;
                    op_a_d       = grant1 ? bus.req1_a      : bus.req0_a;
                    op_b_d       = grant1 ? bus.req1_b      : bus.req0_b;
                    op_cin_d     = grant1 ? bus.req1_cin    : bus.req0_cin;
                    op_id_d      = grant1;
                    last_grant_d = grant1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_id_d       = op_id_q;
                rsp_result_d   = alu_result;
                rsp_mul_high_d = alu_mul_high;
                rsp_mul_low_d  = alu_mul_low;
                rsp_compare_d  = alu_compare;
                rsp_parity_d   = alu_parity;
                rsp_overflow_d = alu_overflow;
                rsp_c_out_d    = alu_c_out;
                state_d        = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            // Reset to 1 so requester 0 wins the first tie
            last_grant_q   <= 1'b1;
            op_opcode_q    <= 3'b000;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_cin_q       <= 1'b0;
            op_id_q        <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_mul_high_q <= '0;
            rsp_mul_low_q  <= '0;
            rsp_compare_q  <= 3'b000;
            rsp_parity_q   <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_c_out_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            op_opcode_q    <= op_opcode_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_cin_q       <= op_cin_d;
            op_id_q        <= op_id_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_mul_high_q <= rsp_mul_high_d;
            rsp_mul_low_q  <= rsp_mul_low_d;
            rsp_compare_q  <= rsp_compare_d;
            rsp_parity_q   <= rsp_parity_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_c_out_q    <= rsp_c_out_d;
        end
    end

    // Derived from the asynchronously reset state, so it drops at once
    assign bus.rsp_valid    = (state_q == S_RESP);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_mul_high = rsp_mul_high_q;
    assign bus.rsp_mul_low  = rsp_mul_low_q;
    assign bus.rsp_compare  = rsp_compare_q;
    assign bus.rsp_parity   = rsp_parity_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_c_out    = rsp_c_out_q;

`ifdef ALU_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-requester accept counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stat_grant0_q, stat_grant0_d;
    logic [CNT_W-1:0] stat_grant1_q, stat_grant1_d;

    always_comb begin
        stat_grant0_d = stat_grant0_q;
        stat_grant1_d = stat_grant1_q;
        if (grant0 && (stat_grant0_q != {CNT_W{1'b1}})) begin
            stat_grant0_d = stat_grant0_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (grant1 && (stat_grant1_q != {CNT_W{1'b1}})) begin
            stat_grant1_d = stat_grant1_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0_q <= '0;
            stat_grant1_q <= '0;
        end else begin
            stat_grant0_q <= stat_grant0_d;
            stat_grant1_q <= stat_grant1_d;
        end
    end

    assign stat_grant0 = stat_grant0_q;
    assign stat_grant1 = stat_grant1_q;
`endif

endmodule : alu_16bit_arbiter
`default_nettype wire

// File: tb/tb_alu_16bit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_16bit_arbiter
//  Description : Self-checking bench for alu_16bit_arbiter. A cycle-level
//                reference model (outstanding-operation bookkeeping plus an
//                arithmetic ALU function) predicts readies, response timing
//                and response contents; directed scenarios are followed by
//                randomized traffic.
//  Config      : honours ALU_ARB_STATS_EN (checks the accept counters)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_16bit_arbiter;
    import alu_pkg::*;

    localparam int DW = 16;
    localparam int CW = 16;

    typedef struct packed {
        logic [15:0] result;
        logic [15:0] mul_high;
        logic [15:0] mul_low;
        logic [2:0]  cmp;
        logic        parity;
        logic        ovf;
        logic        cout;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_16bit_arbiter_if #(.DATA_W(DW)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [CW-1:0] stat_grant0;
    logic [CW-1:0] stat_grant1;
`endif

    alu_16bit_arbiter #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1)
`endif
    );

    // Stimulus state
    logic        req_v   [2];
    logic [2:0]  req_op  [2];
    logic [15:0] req_a   [2];
    logic [15:0] req_b   [2];
    logic        req_cin [2];
    logic        rsp_rdy;

    assign bus.req0_valid  = req_v[0];
    assign bus.req0_opcode = req_op[0];
    assign bus.req0_a      = req_a[0];
    assign bus.req0_b      = req_b[0];
    assign bus.req0_cin    = req_cin[0];
    assign bus.req1_valid  = req_v[1];
    assign bus.req1_opcode = req_op[1];
    assign bus.req1_a      = req_a[1];
    assign bus.req1_b      = req_b[1];
    assign bus.req1_cin    = req_cin[1];
    assign bus.rsp_ready   = rsp_rdy;

    // Reference model state
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   mdl_busy;
    int   mdl_rsp_at;
    bit   mdl_last;
    bit   mdl_id;
    rsp_t mdl_exp;
    int   mdl_stat [2];
    bit   acc      [2];
    int   grant_q  [$];
    int   gcyc_q   [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Arithmetic reference for the ALU
    function automatic rsp_t alu_ref(input logic [2:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic c);
        rsp_t        r;
        int unsigned ua, ub, prod;
        int          sa, sb, v, sv;
        ua = a; ub = b;
        sa = int'($signed(a)); sb = int'($signed(b));
        prod = ua * ub;
        r = '0;
        r.mul_high = 16'(prod >> 16);
        r.mul_low  = 16'(prod);
        r.cmp      = {a < b, a > b, a == b};
        case (op)
            OP_ADD: begin
                v  = int'(ua) + int'(ub) + int'(c);
                sv = sa + sb + int'(c);
                r.result = 16'(v);
                r.cout   = (v > 65535);
                r.ovf    = (sv > 32767) || (sv < -32768);
            end
            OP_SUB: begin
                v  = int'(ua) - int'(ub) - int'(c);
                sv = sa - sb - int'(c);
                r.result = 16'(v);
                r.cout   = (v < 0);
                r.ovf    = (sv > 32767) || (sv < -32768);
            end
            OP_AND: r.result = a & b;
            OP_OR:  r.result = a | b;
            OP_EQ:  r.result = (a == b) ? 16'd1 : 16'd0;
            OP_GT:  r.result = (a >  b) ? 16'd1 : 16'd0;
            OP_LT:  r.result = (a <  b) ? 16'd1 : 16'd0;
            default: begin
                r.result = 16'd0;
                r.ovf    = (prod > 32'd65535);
            end
        endcase
        r.parity = ^r.result;
        return r;
    endfunction

    task automatic model_reset();
        mdl_busy    = 1'b0;
        mdl_rsp_at  = 0;
        mdl_last    = 1'b1;
        mdl_stat[0] = 0;
        mdl_stat[1] = 0;
    endtask

    // One clock cycle: inputs were set at posedge+1; check at negedge,
    // advance the model, return at the next posedge+1.
    task automatic step();
        bit e_r [2];
        bit e_v;
        int w;
        @(negedge clk);
        cyc++;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        e_r[0] = !mdl_busy && req_v[0] && !(req_v[1] && !mdl_last);
        e_r[1] = !mdl_busy && req_v[1] && !(req_v[0] &&  mdl_last);
        e_v    = mdl_busy && (cyc >= mdl_rsp_at);
        check_eq("req0_ready", bus.req0_ready, e_r[0]);
        check_eq("req1_ready", bus.req1_ready, e_r[1]);
        check_eq("rsp_valid",  bus.rsp_valid,  e_v);
        if (e_v) begin
            check_eq("rsp_id",       bus.rsp_id,       mdl_id);
            check_eq("rsp_result",   bus.rsp_result,   mdl_exp.result);
            check_eq("rsp_mul_high", bus.rsp_mul_high, mdl_exp.mul_high);
            check_eq("rsp_mul_low",  bus.rsp_mul_low,  mdl_exp.mul_low);
            check_eq("rsp_compare",  bus.rsp_compare,  mdl_exp.cmp);
            check_eq("rsp_parity",   bus.rsp_parity,   mdl_exp.parity);
            check_eq("rsp_overflow", bus.rsp_overflow, mdl_exp.ovf);
            check_eq("rsp_c_out",    bus.rsp_c_out,    mdl_exp.cout);
        end
`ifdef ALU_ARB_STATS_EN
        check_eq("stat_grant0", stat_grant0, mdl_stat[0]);
        check_eq("stat_grant1", stat_grant1, mdl_stat[1]);
`endif
        if (rst_n) begin
            if (e_v && rsp_rdy) begin
                mdl_busy = 1'b0;
            end else if (e_r[0] || e_r[1]) begin
                w          = e_r[1] ? 1 : 0;
                mdl_exp    = alu_ref(req_op[w], req_a[w], req_b[w], req_cin[w]);
                mdl_id     = e_r[1];
                mdl_busy   = 1'b1;
                mdl_rsp_at = cyc + 2;
                mdl_last   = e_r[1];
                if (mdl_stat[w] < (1 << CW) - 1) mdl_stat[w]++;
                acc[w]     = 1'b1;
                grant_q.push_back(w);
                gcyc_q.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        req_v[i] = 1'b1; req_op[i] = op; req_a[i] = a; req_b[i] = b; req_cin[i] = c;
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_req(input int i);
        issue(i, 3'($urandom), rand_operand(), rand_operand(), 1'($urandom));
    endtask

    // Step until requester i is accepted, then drop its valid
    task automatic wait_accept(input int i);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = acc[i];
        end
        if (!got) check_eq("accept_timeout", 1'b0, 1'b1);
        req_v[i] = 1'b0;
    endtask

    task automatic drain();
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
        rsp_rdy  = 1'b1;
        for (int k = 0; k < 10 && mdl_busy; k++) step();
        step();
    endtask

    task automatic check_rsp_zero(input string tag);
        check_eq({tag, "_result"},   bus.rsp_result,   16'h0);
        check_eq({tag, "_mul_high"}, bus.rsp_mul_high, 16'h0);
        check_eq({tag, "_mul_low"},  bus.rsp_mul_low,  16'h0);
        check_eq({tag, "_compare"},  bus.rsp_compare,  3'b000);
        check_eq({tag, "_flags"},    {bus.rsp_id, bus.rsp_parity, bus.rsp_overflow, bus.rsp_c_out}, 4'h0);
`ifdef ALU_ARB_STATS_EN
        check_eq({tag, "_stat0"}, stat_grant0, 16'h0);
        check_eq({tag, "_stat1"}, stat_grant1, 16'h0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; req_op[i] = 3'b000; req_a[i] = '0; req_b[i] = '0; req_cin[i] = 1'b0;
        end
        rsp_rdy = 1'b0;
        model_reset();

        // ---- Reset: three cycles held low ----
        @(posedge clk); #1;
        repeat (3) step();
        check_rsp_zero("reset");
        rst_n = 1'b1;
        step();

        // ---- Single ADD, response held under backpressure ----
        issue(0, OP_ADD, 16'h00FF, 16'h0F0F, 1'b0);
        wait_accept(0);
        step();
        check_eq("add_result", bus.rsp_result, 16'h100E);
        check_eq("add_parity", bus.rsp_parity, 1'b0);
        check_eq("add_id",     bus.rsp_id,     1'b0);
        repeat (3) step();
        drain();

        // ---- MUL from requester 1 ----
        issue(1, OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
        wait_accept(1);
        step();
        check_eq("mul_id",     bus.rsp_id,       1'b1);
        check_eq("mul_high",   bus.rsp_mul_high, 16'hFFFE);
        check_eq("mul_low",    bus.rsp_mul_low,  16'h0001);
        check_eq("mul_result", bus.rsp_result,   16'h0000);
        drain();

        // ---- Fairness: both valid continuously ----
        grant_q.delete();
        gcyc_q.delete();
        rsp_rdy = 1'b1;
        rand_req(0);
        rand_req(1);
        for (int k = 0; k < 40 && grant_q.size() < 6; k++) begin
            step();
            if (acc[0]) rand_req(0);
            if (acc[1]) rand_req(1);
        end
        check_eq("fair_count", grant_q.size(), 6);
        for (int k = 0; k < 6 && k < grant_q.size(); k++) begin
            check_eq("fair_order", grant_q[k], k % 2);
            if (k > 0) check_eq("fair_spacing", gcyc_q[k] - gcyc_q[k-1], 3);
        end
        drain();

        // ---- Backpressure with requester 1 waiting ----
        rsp_rdy = 1'b0;
        issue(0, OP_LT, 16'h00FF, 16'h0F0F, 1'b0);
        wait_accept(0);
        rand_req(1);
        step();
        check_eq("bp_compare_first", bus.rsp_compare, 3'b100);
        repeat (5) step();
        check_eq("bp_compare_held", bus.rsp_compare, 3'b100);
        check_eq("bp_req1_blocked", bus.req1_ready, 1'b0);
        rsp_rdy = 1'b1;
        step();
        check_eq("bp_req1_ready_idle", bus.req1_ready, 1'b1);
        wait_accept(1);
        drain();

        // ---- Reset during EXEC ----
        rsp_rdy = 1'b1;
        rand_req(1);
        wait_accept(1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_valid", bus.rsp_valid, 1'b0);
        model_reset();
        repeat (2) step();
        check_rsp_zero("midrst");
        rst_n = 1'b1;
        step();
        rand_req(0);
        rand_req(1);
        #1;
        check_eq("tie_after_rst_r0", bus.req0_ready, 1'b1);
        check_eq("tie_after_rst_r1", bus.req1_ready, 1'b0);
        wait_accept(0);
        drain();

        // ---- Randomized traffic ----
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_v[i] && ($urandom_range(0, 1) == 1)) rand_req(i);
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) req_v[i] = 1'b0;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_16bit_arbiter
`default_nettype wire

// File: doc/alu_16bit_arbiter.md
# alu_16bit_arbiter

Shares one `alu_16bit` datapath between two independent requesters through valid/ready handshakes. Round-robin arbitration picks one requester, registers its operands, and captures the ALU outputs. The result is returned on a single tagged response channel. The block sits between the two operation sources and the combinational ALU, so `alu_16bit` itself stays unchanged.

## Interface
- `DATA_W`, 16, operand and result width; must equal the `alu_16bit` width.
- `CNT_W`, 16, width of the statistics counters (used only when stats are compiled in).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester N has an operation pending.
- `req0_ready` / `req1_ready`  out  1  requester N's operation is accepted this cycle.
- `req0_opcode` / `req1_opcode`  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 EQ, 101 GT, 110 LT, 111 MUL.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_W  operands.
- `req0_cin` / `req1_cin`  in  1  carry-in passed to the ALU.
- `rsp_valid`  out  1  response is held on the response channel.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  1  index of the requester that owns the response.
- `rsp_result`, `rsp_mul_high`, `rsp_mul_low`  out  DATA_W  captured ALU outputs.
- `rsp_compare`  out  3  captured compare bits: [2] LT, [1] GT, [0] EQ.
- `rsp_parity`, `rsp_overflow`, `rsp_c_out`  out  1  captured ALU flags.
- `stat_grant0`, `stat_grant1`  out  CNT_W  accept counters; these ports exist only when `ALU_ARB_STATS_EN` is defined.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - Winner selection: only one valid requester → it wins. Both valid → the requester other than `last_grant` wins.
  - `reqN_ready` = (state==IDLE) && winner==N. It is combinational from the valid inputs.
  - An accept is valid && ready for a requester.
  - On accept: latch opcode, a, b, cin and id; set `last_grant` to id; go to EXEC.
- **EXEC**
  - The ALU is driven from the operand registers.
  - At the end of the cycle, all ALU outputs are captured into the `rsp_*` registers; go to RESP.
- **RESP**
  - `rsp_valid`=1 and all `rsp_*` outputs are stable.
  - When `rsp_ready`=1: go to IDLE.
- Both `reqN_ready` are 0 in EXEC and RESP.
- Requester obligations: valid and payload are held stable until ready. The arbiter does not lock a grant across IDLE cycles.
- The block does no result processing: the `rsp_*` values are exactly the `alu_16bit` outputs for the latched operands.
- Opcode values outside the eight listed do not exist, because the field is 3 bits wide.

## Timing
- Reset values: state=IDLE, `last_grant`=1 (so req0 wins the first tie), all `rsp_*`=0, `rsp_valid`=0, `stat_*`=0.
- Latency: accept at edge T → `rsp_valid`=1 after edge T+2.
- Throughput: at most one operation every 3 cycles when `rsp_ready` is held at 1.
  - The edge where RESP completes returns to IDLE.
  - The next accept occurs on the following edge.
- Backpressure: `rsp_ready`=0 holds RESP indefinitely, with outputs unchanged and no new accepts.
- A valid that rises in EXEC or RESP is not accepted until IDLE.
- Reset asserted in any state drops the in-flight operation; `rsp_valid` goes to 0 immediately (asynchronous).
- After reset release, the first accept follows the reset tie rule (req0 wins).

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - `stat_grant0` and `stat_grant1` count accepts per requester.
  - They increment in the accept cycle and saturate at all-ones.
- Not defined: the counters and their ports are absent, and the rest of the behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_ADD` … `OP_MUL`;
  - the FSM state enum `alu_arb_state_t` (IDLE, EXEC, RESP);
  - compare bit indices `CMP_LT`=2, `CMP_GT`=1, `CMP_EQ`=0.
- Single sub-module: the existing `alu_16bit`, instantiated once.
- The arbitration logic is inline.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → `rsp_valid`=0, all `rsp_*`=0, `stat_*`=0.
- **Single ADD:** req0 ADD a=0x00FF b=0x0F0F cin=0 → `rsp_valid` 2 cycles after accept with `rsp_id`=0, `rsp_result`=0x100E, `rsp_parity`=0, and the response held until `rsp_ready`.
- **Fairness:** req0 and req1 both valid continuously for 6 operations, `rsp_ready`=1 → grant order 0,1,0,1,0,1, with 3 cycles between accepts.
- **MUL:** req1 MUL a=0xFFFF b=0xFFFF → `rsp_id`=1, `rsp_mul_high`=0xFFFE, `rsp_mul_low`=0x0001, `rsp_result`=0x0000.
- **Backpressure:** req0 LT a=0x00FF b=0x0F0F, `rsp_ready`=0 for 5 cycles with req1 valid → `rsp_compare`=3'b100 held stable, `req1_ready`=0 throughout, and req1 accepted in the IDLE cycle after the response handshake.
- **Reset mid-operation:** assert `rst_n`=0 during EXEC → `rsp_valid` never rises for that operation, and the next tie is granted to req0. With `ALU_ARB_STATS_EN` defined, the counters read 0 after the reset.
